uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
// - Round-robin arbiter that shares the single UART TX FIFO write port between N_REQ requesters.
// - Sits between client blocks (APB bridge, DMA, debug console) and the TX FIFO in front of uart_tx.
// - Grants are frame-locked: a requester keeps the port until it writes a byte flagged last.
// - No client byte stream interleaves inside another's frame.
// PARAMETERS
// - N_REQ      4   number of requesters (>=2)
// - D_W        8   data byte width, matches the FIFO width
// - MAX_BURST  16  forced-release byte count (UART_ARB_BURST_LIMIT_EN only); >=1
// PORTS
// - clk          in   1          system clock
// - rst          in   1          synchronous reset, active-low
// - module_enable in  1          1 = new grants allowed
// - req_valid    in   N_REQ      per-requester byte valid
// - req_last     in   N_REQ      per-requester: byte is last of frame
// - req_data     in   N_REQ*D_W  requester i data at [i*D_W +: D_W]
// - req_ready    out  N_REQ      per-requester byte accepted this cycle (with valid)
// - ff_full      in   1          TX FIFO full
// - ff_wr_en     out  1          TX FIFO write strobe
// - ff_data      out  D_W        TX FIFO write data
// - grant_id     out  clog2(N_REQ) index of current owner (valid while busy)
// - busy         out  1          1 = state LOCK
// BEHAVIOUR
// - States: IDLE, LOCK.
//   - rst low -> IDLE, rr_ptr=N_REQ-1, grant_id=0, burst_cnt=0.
//   - All outputs 0 in reset.
// - IDLE:
//   - if module_enable && |req_valid -> LOCK next cycle.
//   - grant_id = first valid index searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//   - req_ready=0, ff_wr_en=0 in IDLE.
// - LOCK:
//   - req_ready[g] = (g==grant_id) && !ff_full; all others 0.
//   - Transfer = req_valid[grant_id] && req_ready[grant_id].
//   - ff_wr_en = transfer; ff_data = req_data[grant_id]. Combinational, 0-cycle latency.
//   - Transfer with req_last[grant_id]=1 -> IDLE, rr_ptr<=grant_id.
//   - Owner dropping valid mid-frame -> grant held indefinitely, no timeout.
// - ff_full high: no transfer, grant held.
//   - ff_full is sampled the same cycle; never write when full.
// - One dead IDLE cycle between frames.
//   - Max throughput is 1 byte/clk inside a frame.
// - module_enable low:
//   - In LOCK, the current frame completes normally.
//   - In IDLE, no grant is issued.
// - Simultaneous requests: round-robin order guarantees each waiting requester a grant within N_REQ frames.
// - Reset mid-frame: drops the grant immediately.
//   - Partial frame bytes already in the FIFO stay there; FIFO reset is the owner's job.
// CONFIGURATION
// - UART_ARB_BURST_LIMIT_EN defined:
//   - burst_cnt counts transfers in LOCK.
//   - On the MAX_BURST-th transfer -> IDLE, rr_ptr<=grant_id, even without last.
//   - Requester re-arbitrates for the rest of its frame.
//   - burst_cnt clears on entry to IDLE.
// - Undefined: no burst_cnt register; release only on last.
// STRUCTURE
// - uart_pkg: arb_state_t enum {IDLE,LOCK}.
// - uart_pkg: localparam ARB_IDX_W = $clog2(N_REQ) helper function.
// - Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req vector, rr_ptr.
//   - Outputs: found, idx.
//   - Reusable by future RX fan-out.
// TESTING
// - Single requester 2, 3-byte frame (A1,A2,A3 last), ff_full=0:
//   - grant_id=2 after 1 IDLE cycle.
//   - ff_wr_en high 3 consecutive cycles with A1..A3.
//   - Then IDLE.
// - All 4 valid continuously, 1-byte frames after reset:
//   - Grant order 0,1,2,3,0.
//   - One write every 2 clks.
// - ff_full asserted 5 cycles mid-frame:
//   - ff_wr_en=0 and req_ready=0 for those cycles.
//   - Next byte written the cycle after ff_full falls; no loss or duplication.
// - Owner 1 drops valid 3 cycles mid-frame while requester 0 is valid:
//   - grant_id stays 1.
//   - req_ready[0]=0 throughout.
// - rst low during LOCK:
//   - Next cycle: busy=0, all ready=0.
//   - Next grant goes to lowest valid index.
// - UART_ARB_BURST_LIMIT_EN, MAX_BURST=16, 20-byte frame from requester 0 with requester 1 valid:
//   - 16 bytes from 0, then requester 1 frame, then remaining 4 bytes from 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART TX write-port arbiter
package uart_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  function automatic int arb_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit after rr_ptr, wrapping
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = arb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest candidate after rr_ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - frame-locked round-robin arbiter for the UART TX FIFO write port
// Optional forced release after MAX_BURST bytes: define UART_ARB_BURST_LIMIT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_W       = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     module_enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*D_W-1:0]     req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     ff_full,
  output logic                     ff_wr_en,
  output logic [D_W-1:0]           ff_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int ARB_IDX_W = arb_idx_w(N_REQ);

  arb_state_t           state;
  logic [ARB_IDX_W-1:0] rr_ptr;
  logic                 pick_found;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 xfer;
  logic                 release_frame;
  logic [D_W-1:0]       data_arr [N_REQ];

  if (N_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
    // Unsupported configuration; intentionally left without logic.
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*D_W +: D_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (ARB_IDX_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Gated by rst so a reset mid-frame stops writes in the same cycle.
  always_comb begin
    req_ready = '0;
    if (rst && state == LOCK && !ff_full) req_ready[grant_id] = 1'b1;
  end

  assign xfer     = req_valid[grant_id] && req_ready[grant_id];
  assign ff_wr_en = xfer;
  assign ff_data  = xfer ? data_arr[grant_id] : '0;
  assign busy     = (state == LOCK);

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int BC_W = $clog2(MAX_BURST + 1);
  logic [BC_W-1:0] burst_cnt;

  assign release_frame = xfer && (req_last[grant_id] || burst_cnt == BC_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (release_frame) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign release_frame = xfer && req_last[grant_id];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= ARB_IDX_W'(N_REQ - 1);
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (module_enable && pick_found) begin
            state    <= LOCK;
            grant_id <= pick_idx;
          end
        end
        LOCK: begin
          if (release_frame) begin
            state  <= IDLE;
            rr_ptr <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed vector bench for uart_tx_arb
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic        module_enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ff_full;
  logic        ff_wr_en;
  logic [7:0]  ff_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arb #(.N_REQ(4), .D_W(8), .MAX_BURST(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .module_enable (module_enable),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .ff_full       (ff_full),
    .ff_wr_en      (ff_wr_en),
    .ff_data       (ff_data),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic [3:0]  x_rdy;
    logic        x_wr;
    logic [7:0]  x_dat;
    logic [1:0]  x_gid;
    logic        x_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, e, input logic [3:0] v, l, input logic [31:0] d,
                              input logic f, input logic [3:0] x_rdy, input logic x_wr,
                              input logic [7:0] x_dat, input logic [1:0] x_gid, input logic x_busy);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.l = l; t.d = d; t.f = f;
    t.x_rdy = x_rdy; t.x_wr = x_wr; t.x_dat = x_dat; t.x_gid = x_gid; t.x_busy = x_busy;
    return t;
  endfunction

  task automatic drive(input logic r, e, input logic [3:0] v, l, input logic [31:0] d, input logic f);
    @(negedge clk);
    rst = r; module_enable = e; req_valid = v; req_last = l; req_data = d; ff_full = f;
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int b;
  int k0, k1, nw;
  logic xw, full;
  logic [7:0] expq[$];

  initial begin
    rst = 1'b0; module_enable = 1'b0; req_valid = '0; req_last = '0; req_data = '0; ff_full = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, single 3-byte frame from requester 2, then 1-byte frames from all four.
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 32'h0,         0, 4'b0000, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 1, 4'b0100, 4'b0000, 32'h00A10000,  0, 4'b0000, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 1, 4'b0100, 4'b0000, 32'h00A10000,  0, 4'b0100, 1, 8'hA1, 2'd2, 1));
    tbl.push_back(mk(1, 1, 4'b0100, 4'b0000, 32'h00A20000,  0, 4'b0100, 1, 8'hA2, 2'd2, 1));
    tbl.push_back(mk(1, 1, 4'b0100, 4'b0100, 32'h00A30000,  0, 4'b0100, 1, 8'hA3, 2'd2, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 4'b0000, 32'h0,         0, 4'b0000, 0, 8'h00, 2'd2, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 32'h0,         0, 4'b0000, 0, 8'h00, 2'd2, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0000, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0001, 1, 8'h10, 2'd0, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0000, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0010, 1, 8'h11, 2'd1, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0000, 0, 8'h00, 2'd1, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0100, 1, 8'h12, 2'd2, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0000, 0, 8'h00, 2'd2, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b1000, 1, 8'h13, 2'd3, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0000, 0, 8'h00, 2'd3, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h13121110,  0, 4'b0001, 1, 8'h10, 2'd0, 1));
    tbl.push_back(mk(1, 1, 4'b0000, 4'b0000, 32'h0,         0, 4'b0000, 0, 8'h00, 2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      chk($sformatf("vec%0d_rdy", i), req_ready, tbl[i].x_rdy);
      chk($sformatf("vec%0d_wr", i), ff_wr_en, tbl[i].x_wr);
      if (tbl[i].x_wr) chk($sformatf("vec%0d_dat", i), ff_data, tbl[i].x_dat);
      chk($sformatf("vec%0d_gid", i), grant_id, tbl[i].x_gid);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].x_busy);
    end

    // FIFO full for 5 cycles inside a 4-byte frame from requester 3.
    b = 0;
    for (int c = 0; c < 11; c++) begin
      full = (c >= 2 && c <= 6);
      xw   = (c == 1 || c == 7 || c == 8 || c == 9);
      drive(1, 1, (b < 4) ? 4'b1000 : 4'b0000, (b == 3) ? 4'b1000 : 4'b0000,
            {8'hC0 + b[7:0], 24'h0}, full);
      chk("ffull_wr", ff_wr_en, xw);
      chk("ffull_rdy", req_ready, (c >= 1 && c <= 9 && !full) ? 4'b1000 : 4'b0000);
      if (xw) begin
        chk("ffull_dat", ff_data, 8'hC0 + b[7:0]);
        b++;
      end
    end
    chk("ffull_bytes", b, 4);

    // Owner 1 stalls mid-frame while requester 0 waits.
    drive(1, 1, 4'b0010, 4'b0000, 32'h00005100, 0);
    chk("stall_idle_busy", busy, 1'b0);
    drive(1, 1, 4'b0011, 4'b0000, 32'h0000510F, 0);
    chk("stall_gid", grant_id, 2'd1);
    chk("stall_wr0", ff_wr_en, 1'b1);
    chk("stall_dat0", ff_data, 8'h51);
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 4'b0001, 4'b0000, 32'h0000520F, 0);
      chk("stall_hold_gid", grant_id, 2'd1);
      chk("stall_hold_rdy", req_ready, 4'b0010);
      chk("stall_hold_wr", ff_wr_en, 1'b0);
    end
    drive(1, 1, 4'b0011, 4'b0011, 32'h0000520F, 0);
    chk("stall_last_dat", ff_data, 8'h52);
    chk("stall_last_rdy", req_ready, 4'b0010);
    drive(1, 1, 4'b0001, 4'b0001, 32'h0000000F, 0);
    chk("stall_gap_busy", busy, 1'b0);
    chk("stall_gap_rdy", req_ready, 4'b0000);
    drive(1, 1, 4'b0001, 4'b0001, 32'h0000000F, 0);
    chk("stall_next_gid", grant_id, 2'd0);
    chk("stall_next_dat", ff_data, 8'h0F);
    drive(1, 1, 4'b0000, 4'b0000, 32'h0, 0);

    // Reset during LOCK drops the grant at once; next grant goes to lowest valid index.
    drive(1, 1, 4'b0100, 4'b0000, 32'h00330000, 0);
    drive(1, 1, 4'b0100, 4'b0000, 32'h00330000, 0);
    chk("rst_pre_gid", grant_id, 2'd2);
    chk("rst_pre_wr", ff_wr_en, 1'b1);
    drive(0, 1, 4'b0110, 4'b0000, 32'h00334400, 0);
    chk("rst_in_rdy", req_ready, 4'b0000);
    chk("rst_in_wr", ff_wr_en, 1'b0);
    drive(1, 1, 4'b0110, 4'b0010, 32'h00334400, 0);
    chk("rst_post_busy", busy, 1'b0);
    chk("rst_post_rdy", req_ready, 4'b0000);
    chk("rst_post_gid", grant_id, 2'd0);
    drive(1, 1, 4'b0110, 4'b0010, 32'h00334400, 0);
    chk("rst_next_gid", grant_id, 2'd1);
    chk("rst_next_dat", ff_data, 8'h44);
    drive(1, 1, 4'b0000, 4'b0000, 32'h0, 0);

    // module_enable low: no new grant in IDLE, current frame still completes.
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 4'b1000, 4'b0000, 32'h55000000, 0);
      chk("en_low_busy", busy, 1'b0);
    end
    drive(1, 1, 4'b1000, 4'b0000, 32'h55000000, 0);
    chk("en_grant_idle", busy, 1'b0);
    drive(1, 0, 4'b1000, 4'b0000, 32'h55000000, 0);
    chk("en_lock_gid", grant_id, 2'd3);
    chk("en_lock_wr", ff_wr_en, 1'b1);
    drive(1, 0, 4'b1000, 4'b1000, 32'h56000000, 0);
    chk("en_lock_last", ff_data, 8'h56);
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 4'b1000, 4'b0000, 32'h57000000, 0);
      chk("en_after_busy", busy, 1'b0);
    end

`ifdef UART_ARB_BURST_LIMIT_EN
    // 20-byte frame from requester 0 is split after 16 bytes to let requester 1 in.
    drive(0, 0, 4'b0000, 4'b0000, 32'h0, 0);
    for (int i = 0; i < 16; i++) expq.push_back(8'(i));
    expq.push_back(8'h80);
    expq.push_back(8'h81);
    for (int i = 16; i < 20; i++) expq.push_back(8'(i));
    k0 = 0; k1 = 0; nw = 0;
    for (int c = 0; c < 60 && nw < 22; c++) begin
      drive(1, 1, {2'b00, k1 < 2, k0 < 20}, {2'b00, k1 == 1, k0 == 19},
            {16'h0, 8'h80 + k1[7:0], k0[7:0]}, 0);
      if (ff_wr_en) begin
        chk("burst_dat", ff_data, expq[nw]);
        nw++;
        if (req_ready[0]) k0++;
        if (req_ready[1]) k1++;
      end
    end
    chk("burst_writes", nw, 22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
